// File: rtl/pkt_dbuf.sv
// Double-buffered packet memory: a valid/ready stream fills one bank while the core loads from the other.
// Define PKT_DBUF_BSWAP_EN to return multi-byte loads in network (big-endian) byte order.
module pkt_dbuf #(
   parameter int PKT_BYTES = 128,
   parameter int IN_W      = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [IN_W-1:0]            in_data,
   input  logic                       in_last,
   input  logic                       pkt_done,
   output logic                       pkt_avail,
   output logic [$clog2(PKT_BYTES):0] pkt_len,
   output logic                       pkt_trunc,
   input  logic                       rd_en,
   input  logic [63:0]                rd_off,
   input  logic [1:0]                 rd_size,
   output logic                       rd_valid,
   output logic [63:0]                rd_data,
   output logic                       rd_fault
);

   localparam int AW = $clog2(PKT_BYTES);
   localparam int LW = AW + 1;
   localparam int BB = IN_W / 8;

   typedef enum logic [1:0] {F_IDLE, F_FILL, F_DRAIN, F_WAIT} fill_state_t;

   fill_state_t   state, state_nxt;
   logic [7:0]    mem [0:2*PKT_BYTES-1];
   logic          act;
   logic          fill_bank;
   logic [LW-1:0] len_r [2];
   logic          trunc_r [2];
   logic [LW-1:0] fptr, fptr_nxt, fptr_inc;
   logic          accept, wr_en, done_pkt, done_trunc, swap;
   logic [LW-1:0] done_len;
   logic [3:0]    rd_n;
   logic [64:0]   rd_end;
   logic          rd_bad;
   logic [63:0]   ld;

   assign fill_bank = ~act;
   assign in_ready  = !rst && (state != F_WAIT);
   assign accept    = in_valid && in_ready;
   assign fptr_inc  = fptr + LW'(BB);
   assign pkt_len   = pkt_avail ? len_r[act] : '0;
   assign pkt_trunc = pkt_avail && trunc_r[act];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= F_IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt  = state;
      fptr_nxt   = fptr;
      wr_en      = 1'b0;
      done_pkt   = 1'b0;
      done_len   = fptr_inc;
      done_trunc = 1'b0;
      swap       = 1'b0;
      case (state)
         F_IDLE, F_FILL: begin
            if (accept) begin
               wr_en    = 1'b1;
               fptr_nxt = fptr_inc;
               if (in_last)                            done_pkt  = 1'b1;
               else if (fptr_inc == LW'(PKT_BYTES))    state_nxt = F_DRAIN;
               else                                    state_nxt = F_FILL;
            end
         end
         F_DRAIN: begin
            if (accept && in_last) begin
               done_pkt   = 1'b1;
               done_len   = LW'(PKT_BYTES);
               done_trunc = 1'b1;
            end
         end
         F_WAIT: begin
            if (pkt_done) begin
               swap      = 1'b1;
               state_nxt = F_IDLE;
            end
         end
         default: state_nxt = F_IDLE;
      endcase
      // A completed packet takes over at once unless the core still owns the active bank.
      if (done_pkt) begin
         fptr_nxt = '0;
         if (!pkt_avail || pkt_done) begin
            swap      = 1'b1;
            state_nxt = F_IDLE;
         end else begin
            state_nxt = F_WAIT;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act        <= 1'b0;
         pkt_avail  <= 1'b0;
         fptr       <= '0;
         len_r[0]   <= '0;
         len_r[1]   <= '0;
         trunc_r[0] <= 1'b0;
         trunc_r[1] <= 1'b0;
      end else begin
         fptr <= fptr_nxt;
         if (done_pkt) begin
            len_r[fill_bank]   <= done_len;
            trunc_r[fill_bank] <= done_trunc;
         end
         if (swap) begin
            act       <= ~act;
            pkt_avail <= 1'b1;
         end else if (pkt_done) begin
            pkt_avail <= 1'b0;
         end
      end
   end

   // NOTE: the bank RAM has no reset; stale bytes stay hidden because loads are bounded by len.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int k = 0; k < BB; k++)
            mem[{fill_bank, AW'(fptr[AW-1:0] + AW'(k))}] <= in_data[8*k +: 8];
      end
   end

   // 65-bit end offset so offsets near 2^64 cannot wrap into range.
   assign rd_n   = 4'd1 << rd_size;
   assign rd_end = {1'b0, rd_off} + 65'(rd_n);
   assign rd_bad = !pkt_avail || (rd_end > 65'(len_r[act]));

   always_comb begin
      ld = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < int'(rd_n)) begin
`ifdef PKT_DBUF_BSWAP_EN
            ld[8*(int'(rd_n)-1-i) +: 8] = mem[{act, AW'(rd_off[AW-1:0] + AW'(i))}];
`else
            ld[8*i +: 8] = mem[{act, AW'(rd_off[AW-1:0] + AW'(i))}];
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
         rd_fault <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         rd_fault <= rd_en && rd_bad;
         rd_data  <= (rd_en && !rd_bad) ? ld : '0;
      end
   end

endmodule

// File: tb/tb_pkt_dbuf.sv
// Self-checking bench for pkt_dbuf: directed scenarios plus randomized fills/loads against a byte-array model.
module tb_pkt_dbuf;
   localparam int PKT_BYTES = 128;
   localparam int IN_W      = 64;
   localparam int BB        = IN_W / 8;
   localparam int LW        = $clog2(PKT_BYTES) + 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid, in_ready, in_last, pkt_done;
   logic [IN_W-1:0] in_data;
   logic            pkt_avail, pkt_trunc;
   logic [LW-1:0]   pkt_len;
   logic            rd_en, rd_valid, rd_fault;
   logic [63:0]     rd_off, rd_data;
   logic [1:0]      rd_size;

   int errors = 0;
   int checks = 0;

   // Reference model: the active packet and a fill waiting for release, as plain byte arrays.
   logic [7:0] m_bytes [PKT_BYTES];
   int         m_len;
   bit         m_trunc, m_avail;
   logic [7:0] p_bytes [PKT_BYTES];
   int         p_len;
   bit         p_trunc, p_valid;

   pkt_dbuf #(.PKT_BYTES(PKT_BYTES), .IN_W(IN_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .pkt_done(pkt_done), .pkt_avail(pkt_avail), .pkt_len(pkt_len), .pkt_trunc(pkt_trunc),
      .rd_en(rd_en), .rd_off(rd_off), .rd_size(rd_size),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_fault(rd_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [64:0] exp_load(input logic [63:0] off, input logic [1:0] size);
      int          n = 1 << size;
      logic [63:0] v = '0;
      if (!m_avail || off >= 64'(m_len) || (64'(m_len) - off) < 64'(n))
         return {1'b1, 64'd0};
      for (int i = 0; i < n; i++) begin
`ifdef PKT_DBUF_BSWAP_EN
         v = (v << 8) | 64'(m_bytes[int'(off) + i]);
`else
         v = v | (64'(m_bytes[int'(off) + i]) << (8 * i));
`endif
      end
      return {1'b0, v};
   endfunction

   function automatic void model_release();
      if (p_valid) begin
         m_bytes = p_bytes;
         m_len   = p_len;
         m_trunc = p_trunc;
         m_avail = 1'b1;
         p_valid = 1'b0;
      end else begin
         m_avail = 1'b0;
      end
   endfunction

   // Streams nbeats beats (pattern byte = running index, or random); optional pkt_done with the last beat.
   task automatic send_packet(input int nbeats, input bit rnd, input bit done_last, output int accepted);
      logic [IN_W-1:0] d;
      logic [7:0]      all[$];
      logic [7:0]      nb [PKT_BYTES];
      int              wait_cyc, total, len;
      accepted = 0;
      for (int b = 0; b < nbeats; b++) begin
         for (int k = 0; k < BB; k++) d[8*k +: 8] = rnd ? 8'($urandom) : 8'(b * BB + k);
         in_valid = 1'b1;
         in_data  = d;
         in_last  = (b == nbeats - 1);
         wait_cyc = 0;
         while (!in_ready && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
         end
         checks++;
         if (!in_ready) begin
            $display("FAIL send_beat_timeout: beat %0d in_ready=%b after %0d cycles, required 1", b, in_ready, wait_cyc);
            errors++;
            break;
         end
         pkt_done = done_last && in_last;
         @(negedge clk);
         accepted++;
         for (int k = 0; k < BB; k++) all.push_back(d[8*k +: 8]);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      pkt_done = 1'b0;
      if (accepted == nbeats) begin
         total = nbeats * BB;
         len   = (total > PKT_BYTES) ? PKT_BYTES : total;
         for (int i = 0; i < PKT_BYTES; i++) nb[i] = (i < len) ? all[i] : 8'h00;
         if (!m_avail || done_last) begin
            m_bytes = nb; m_len = len; m_trunc = (total > PKT_BYTES); m_avail = 1'b1;
         end else begin
            p_bytes = nb; p_len = len; p_trunc = (total > PKT_BYTES); p_valid = 1'b1;
         end
      end
   endtask

   task automatic do_load(input logic [63:0] off, input logic [1:0] size,
                          output logic v, output logic [63:0] d, output logic f);
      rd_en = 1'b1; rd_off = off; rd_size = size;
      @(negedge clk);
      rd_en = 1'b0;
      v = rd_valid; d = rd_data; f = rd_fault;
   endtask

   task automatic release_pkt();
      pkt_done = 1'b1;
      @(negedge clk);
      pkt_done = 1'b0;
      if (m_avail) model_release();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0; pkt_done = 1'b0;
      rd_en = 1'b0; rd_off = '0; rd_size = 2'b00;
      m_avail = 1'b0; p_valid = 1'b0; m_len = 0; m_trunc = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({pkt_avail, pkt_len, pkt_trunc, rd_valid, rd_data, rd_fault, in_ready} !== '0) begin
         $display("FAIL reset_outputs: avail=%b len=%0d trunc=%b rv=%b rd=%h rf=%b rdy=%b, required all 0",
                  pkt_avail, pkt_len, pkt_trunc, rd_valid, rd_data, rd_fault, in_ready);
         errors++;
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || pkt_avail !== 1'b0) begin
         $display("FAIL post_reset_idle: in_ready=%b pkt_avail=%b, required 1/0", in_ready, pkt_avail);
         errors++;
      end
   endtask

   task automatic test_fill_load();
      int acc; logic v, f; logic [63:0] d, want;
      send_packet(2, 1'b0, 1'b0, acc);
      checks++;
      if (pkt_avail !== 1'b1 || pkt_len !== LW'(16) || pkt_trunc !== 1'b0) begin
         $display("FAIL fill_status: avail=%b len=%0d trunc=%b, required 1/16/0", pkt_avail, pkt_len, pkt_trunc);
         errors++;
      end
`ifdef PKT_DBUF_BSWAP_EN
      want = 64'h0000_0000_0405_0607;
`else
      want = 64'h0000_0000_0706_0504;
`endif
      do_load(64'd4, 2'b10, v, d, f);
      checks++;
      if (v !== 1'b1 || f !== 1'b0 || d !== want) begin
         $display("FAIL load_w_off4: valid=%b fault=%b data=%h, required 1/0/%h", v, f, d, want);
         errors++;
      end
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b0) begin
         $display("FAIL rd_valid_one_cycle: rd_valid=%b, required 0", rd_valid);
         errors++;
      end
   endtask

   task automatic test_bounds();
      logic [63:0] offs  [6] = '{64'd8, 64'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd15, 64'd15, 64'h8000_0000_0000_0000};
      logic [1:0]  sizes [6] = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00};
      logic        faults[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      logic v, f; logic [63:0] d; logic [64:0] e;
      for (int i = 0; i < 6; i++) begin
         e = exp_load(offs[i], sizes[i]);
         do_load(offs[i], sizes[i], v, d, f);
         checks++;
         if (v !== 1'b1 || f !== faults[i] || d !== e[63:0]) begin
            $display("FAIL bounds_%0d: off=%h size=%0d fault=%b data=%h, required fault=%b data=%h",
                     i, offs[i], sizes[i], f, d, faults[i], e[63:0]);
            errors++;
         end
      end
   endtask

   task automatic test_back_to_back();
      int acc; logic [64:0] ea;
      send_packet(3, 1'b1, 1'b0, acc);
      checks++;
      if (in_ready !== 1'b0 || pkt_len !== LW'(16)) begin
         $display("FAIL fill_wait: in_ready=%b pkt_len=%0d, required 0/16", in_ready, pkt_len);
         errors++;
      end
      ea = exp_load(64'd4, 2'b10);
      pkt_done = 1'b1; rd_en = 1'b1; rd_off = 64'd4; rd_size = 2'b10;
      @(negedge clk);
      pkt_done = 1'b0; rd_en = 1'b0;
      model_release();
      checks++;
      if (rd_fault !== ea[64] || rd_data !== ea[63:0]) begin
         $display("FAIL swap_cycle_load: fault=%b data=%h, required %b/%h", rd_fault, rd_data, ea[64], ea[63:0]);
         errors++;
      end
      checks++;
      if (pkt_len !== LW'(24) || in_ready !== 1'b1 || pkt_avail !== 1'b1) begin
         $display("FAIL swap_status: len=%0d rdy=%b avail=%b, required 24/1/1", pkt_len, in_ready, pkt_avail);
         errors++;
      end
   endtask

   task automatic test_trunc();
      int acc; logic v, f; logic [63:0] d;
      release_pkt();
      checks++;
      if (pkt_avail !== 1'b0) begin
         $display("FAIL release_clears: pkt_avail=%b, required 0", pkt_avail);
         errors++;
      end
      send_packet(20, 1'b0, 1'b0, acc);
      checks++;
      if (acc !== 20 || pkt_len !== LW'(128) || pkt_trunc !== 1'b1 || in_ready !== 1'b1) begin
         $display("FAIL trunc_status: accepted=%0d len=%0d trunc=%b rdy=%b, required 20/128/1/1",
                  acc, pkt_len, pkt_trunc, in_ready);
         errors++;
      end
      do_load(64'd127, 2'b00, v, d, f);
      checks++;
      if (f !== 1'b0 || d !== 64'h7F) begin
         $display("FAIL trunc_byte127: fault=%b data=%h, required 0/7f", f, d);
         errors++;
      end
      do_load(64'd128, 2'b00, v, d, f);
      checks++;
      if (f !== 1'b1 || d !== 64'd0) begin
         $display("FAIL trunc_byte128: fault=%b data=%h, required 1/0", f, d);
         errors++;
      end
   endtask

   task automatic test_no_packet();
      logic v, f; logic [63:0] d; int acc;
      release_pkt();
      do_load(64'd0, 2'b00, v, d, f);
      checks++;
      if (f !== 1'b1 || d !== 64'd0 || v !== 1'b1) begin
         $display("FAIL empty_load: valid=%b fault=%b data=%h, required 1/1/0", v, f, d);
         errors++;
      end
      release_pkt();
      checks++;
      if (pkt_avail !== 1'b0 || pkt_len !== '0 || in_ready !== 1'b1) begin
         $display("FAIL empty_done: avail=%b len=%0d rdy=%b, required 0/0/1", pkt_avail, pkt_len, in_ready);
         errors++;
      end
      send_packet(5, 1'b1, 1'b0, acc);
      checks++;
      if (pkt_len !== LW'(m_len) || pkt_avail !== 1'b1) begin
         $display("FAIL empty_refill: len=%0d avail=%b, required %0d/1", pkt_len, pkt_avail, m_len);
         errors++;
      end
   endtask

   task automatic test_random();
      int acc, act, nb; logic [63:0] off; logic [1:0] sz; logic [64:0] e;
      for (int it = 0; it < 40; it++) begin
         act = $urandom_range(0, 3);
         if (act == 0 && !p_valid) begin
            nb = $urandom_range(1, 20);
            send_packet(nb, 1'b1, 1'(($urandom_range(0, 3) == 0)), acc);
         end else if (act == 1) begin
            release_pkt();
         end else begin
            for (int j = 0; j < 6; j++) begin
               sz = 2'($urandom_range(0, 3));
               case ($urandom_range(0, 9))
                  8:       off = {$urandom, $urandom};
                  9:       off = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
                  default: off = 64'($urandom_range(0, m_len + 4));
               endcase
               e = exp_load(off, sz);
               rd_en = 1'b1; rd_off = off; rd_size = sz;
               @(negedge clk);
               checks++;
               if (rd_valid !== 1'b1 || rd_fault !== e[64] || rd_data !== e[63:0]) begin
                  $display("FAIL rand_load: off=%h size=%0d valid=%b fault=%b data=%h, required 1/%b/%h",
                           off, sz, rd_valid, rd_fault, rd_data, e[64], e[63:0]);
                  errors++;
               end
            end
            rd_en = 1'b0;
         end
         checks++;
         if (pkt_avail !== m_avail || pkt_len !== (m_avail ? LW'(m_len) : LW'(0)) ||
             pkt_trunc !== (m_avail && m_trunc) || in_ready !== !p_valid) begin
            $display("FAIL rand_status: avail=%b len=%0d trunc=%b rdy=%b, required %b/%0d/%b/%b",
                     pkt_avail, pkt_len, pkt_trunc, in_ready, m_avail, m_avail ? m_len : 0,
                     m_avail && m_trunc, !p_valid);
            errors++;
         end
      end
   endtask

   task automatic test_async_reset();
      int acc; logic v, f; logic [63:0] d; logic [64:0] e;
      if (p_valid) release_pkt();
      if (!m_avail) send_packet(2, 1'b1, 1'b0, acc);
      in_valid = 1'b1; in_last = 1'b0; in_data = {$urandom, $urandom};
      rd_en = 1'b1; rd_off = 64'd0; rd_size = 2'b00;
      repeat (2) @(negedge clk);
      checks++;
      if (rd_valid !== 1'b1 || pkt_avail !== 1'b1) begin
         $display("FAIL pre_reset_busy: rd_valid=%b avail=%b, required 1/1", rd_valid, pkt_avail);
         errors++;
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({pkt_avail, pkt_len, pkt_trunc, rd_valid, rd_data, rd_fault, in_ready} !== '0) begin
         $display("FAIL async_reset: avail=%b len=%0d trunc=%b rv=%b rd=%h rf=%b rdy=%b, required all 0",
                  pkt_avail, pkt_len, pkt_trunc, rd_valid, rd_data, rd_fault, in_ready);
         errors++;
      end
      @(negedge clk);
      in_valid = 1'b0; rd_en = 1'b0;
      rst = 1'b0;
      m_avail = 1'b0; p_valid = 1'b0;
      @(negedge clk);
      send_packet(4, 1'b1, 1'b0, acc);
      checks++;
      if (pkt_len !== LW'(32) || pkt_avail !== 1'b1) begin
         $display("FAIL post_reset_fill: len=%0d avail=%b, required 32/1", pkt_len, pkt_avail);
         errors++;
      end
      for (int i = 0; i < 4; i++) begin
         e = exp_load(64'(i * 7), 2'(i));
         do_load(64'(i * 7), 2'(i), v, d, f);
         checks++;
         if (f !== e[64] || d !== e[63:0]) begin
            $display("FAIL post_reset_load_%0d: fault=%b data=%h, required %b/%h", i, f, d, e[64], e[63:0]);
            errors++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill_load();
      test_bounds();
      test_back_to_back();
      test_trunc();
      test_no_packet();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
